// File: rtl/can_stream_pkg.sv
// can_stream_pkg: shared FSM states and bus constants for the CAN bit streamer
package can_stream_pkg;
    typedef enum logic [1:0] {IDLE, ARM, SEND, GAP} state_t;
    localparam int unsigned STUFF_RUN = 5;
    localparam logic RECESSIVE = 1'b1;
endpackage

// File: rtl/can_bit_timer.sv
// can_bit_timer: free-running bit-time counter with sample and pre-boundary strobes
module can_bit_timer #(
    parameter int CLK_PER_BIT = 10,
    parameter int SAMPLE_POS  = 9
) (
    input  logic clock,
    input  logic reset,
    output logic sample_point,
    output logic pre_boundary
);
    localparam int TQ_W = $clog2(CLK_PER_BIT);
    logic [TQ_W-1:0] tq_q, tq_d;
    // count 0..CLK_PER_BIT-1 and wrap
    always_comb tq_d = (tq_q == TQ_W'(CLK_PER_BIT - 1)) ? '0 : tq_q + TQ_W'(1);
    // timer register, cleared by reset
    always_ff @(posedge clock) begin
        if (!reset) tq_q <= '0;
        else        tq_q <= tq_d;
    end
    assign sample_point = tq_q == TQ_W'(SAMPLE_POS);
    // high in the last clock of a bit: registered outputs then change on the boundary cycle
    assign pre_boundary = tq_q == TQ_W'(CLK_PER_BIT - 1);
endmodule

// File: rtl/can_bit_streamer.sv
// can_bit_streamer: CAN bit-stream generator; define CAN_STREAM_STUFF_EN for bit stuffing
module can_bit_streamer
    import can_stream_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 512,
    parameter int CLK_PER_BIT   = 10,
    parameter int SAMPLE_POS    = 9,
    parameter int IDX_W         = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MAX_FRAME_LEN-1:0] frame_bits,
    input  logic [IDX_W-1:0]         num_bits,
    input  logic [IDX_W-1:0]         stuff_len,
    input  logic [7:0]               repeat_cnt,
    input  logic [7:0]               gap_bits,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rx_bit,
    output logic                     sample_point,
    output logic [IDX_W:0]           bit_count,
    output logic [IDX_W-1:0]         stuff_count
);
    localparam int CW = IDX_W + 1;
    localparam logic [MAX_FRAME_LEN-1:0] ONE = MAX_FRAME_LEN'(1);
    state_t                   state_q, state_d;
    logic [MAX_FRAME_LEN-1:0] frame_q, frame_d, f;
    logic [IDX_W-1:0]         nbits_q, nbits_d, sent_q, sent_d, n, clamp;
    logic [7:0]               rep_q, rep_d, gap_q, gap_d, left_q, left_d, gap_cnt_q, gap_cnt_d, rep;
    logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]         stuff_cnt_q, stuff_cnt_d;
    logic                     rx_q, rx_d, done_q, done_d;
    logic                     pre_boundary, take, new_frame, fb_first, fb_next, stuff_now;
    can_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT), .SAMPLE_POS(SAMPLE_POS)) u_timer (
        .clock        (clock),
        .reset        (reset),
        .sample_point (sample_point),
        .pre_boundary (pre_boundary)
    );
    assign take  = (state_q == IDLE) && start;
    assign clamp = (num_bits > IDX_W'(MAX_FRAME_LEN)) ? IDX_W'(MAX_FRAME_LEN) : num_bits;
    // a start landing on the last clock of a bit uses the live inputs before they reach the shadows
    assign f   = take ? frame_bits : frame_q;
    assign n   = take ? clamp : nbits_q;
    assign rep = take ? repeat_cnt : rep_q;
    assign fb_first = |(f & (ONE << (n - IDX_W'(1))));
    assign fb_next  = |(frame_q & (ONE << (nbits_q - sent_q - IDX_W'(1))));
`ifdef CAN_STREAM_STUFF_EN
    logic [IDX_W-1:0] slen_q, slen_d;
    logic [2:0]       run_q, run_d;
    // stuff after five equal bits whose fifth frame index lies inside the stuffed region
    assign stuff_now = (run_q == 3'(STUFF_RUN)) && (sent_q <= slen_q);
`else
    logic unused_stuff_len;
    assign unused_stuff_len = ^stuff_len;
    assign stuff_now = 1'b0;
`endif
    // next-state and output logic, decisions taken in the last clock of each bit time
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        nbits_d     = nbits_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        left_d      = left_q;
        gap_cnt_d   = gap_cnt_q;
        sent_d      = sent_q;
        rx_d        = rx_q;
        done_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        stuff_cnt_d = stuff_cnt_q;
        new_frame   = 1'b0;
`ifdef CAN_STREAM_STUFF_EN
        slen_d = slen_q;
        run_d  = run_q;
`endif
        if (take) begin
            state_d = ARM;
            frame_d = frame_bits;
            nbits_d = clamp;
            rep_d   = repeat_cnt;
            gap_d   = gap_bits;
`ifdef CAN_STREAM_STUFF_EN
            slen_d = stuff_len;
`endif
        end
        if (pre_boundary) begin
            if (take || state_q == ARM) begin
                left_d = rep;
                if (n == '0) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    rx_d        = RECESSIVE;
                    bit_cnt_d   = '0;
                    stuff_cnt_d = '0;
                end else begin
                    new_frame = 1'b1;
                end
            end else if (state_q == SEND) begin
                if (stuff_now) begin
                    rx_d        = ~rx_q;
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    stuff_cnt_d = stuff_cnt_q + IDX_W'(1);
`ifdef CAN_STREAM_STUFF_EN
                    run_d = 3'd1;
`endif
                end else if (sent_q < nbits_q) begin
                    rx_d      = fb_next;
                    sent_d    = sent_q + IDX_W'(1);
                    bit_cnt_d = bit_cnt_q + CW'(1);
`ifdef CAN_STREAM_STUFF_EN
                    run_d = (fb_next != rx_q) ? 3'd1 : (run_q == 3'(STUFF_RUN)) ? run_q : run_q + 3'd1;
`endif
                end else if (left_q != 8'd0) begin
                    left_d = left_q - 8'd1;
                    if (gap_q != 8'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                        rx_d      = RECESSIVE;
                    end else begin
                        new_frame = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rx_d    = RECESSIVE;
                end
            end else if (state_q == GAP) begin
                if (gap_cnt_q == 8'd1) new_frame = 1'b1;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
        end
        if (new_frame) begin
            state_d     = SEND;
            rx_d        = fb_first;
            sent_d      = IDX_W'(1);
            bit_cnt_d   = CW'(1);
            stuff_cnt_d = '0;
`ifdef CAN_STREAM_STUFF_EN
            run_d = 3'd1;
`endif
        end
    end
    // state and shadow registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            nbits_q     <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            left_q      <= '0;
            gap_cnt_q   <= '0;
            sent_q      <= '0;
            rx_q        <= RECESSIVE;
            done_q      <= 1'b0;
            bit_cnt_q   <= '0;
            stuff_cnt_q <= '0;
`ifdef CAN_STREAM_STUFF_EN
            slen_q <= '0;
            run_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            nbits_q     <= nbits_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            left_q      <= left_d;
            gap_cnt_q   <= gap_cnt_d;
            sent_q      <= sent_d;
            rx_q        <= rx_d;
            done_q      <= done_d;
            bit_cnt_q   <= bit_cnt_d;
            stuff_cnt_q <= stuff_cnt_d;
`ifdef CAN_STREAM_STUFF_EN
            slen_q <= slen_d;
            run_q  <= run_d;
`endif
        end
    end
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign rx_bit      = rx_q;
    assign bit_count   = bit_cnt_q;
    assign stuff_count = stuff_cnt_q;
endmodule

// File: tb/tb_can_bit_streamer.sv
// tb_can_bit_streamer: directed and random transfers checked against a bit-list model
module tb_can_bit_streamer;
    localparam int MAXL = 64;
    localparam int CLK  = 10;
    localparam int SP   = 7;
    localparam int IW   = 7;
    logic            clk, reset, start, busy, done, rx_bit, sample_point;
    logic [MAXL-1:0] frame_bits;
    logic [IW-1:0]   num_bits, stuff_len, bit_count_unused_guard;
    logic [7:0]      repeat_cnt, gap_bits;
    logic [IW:0]     bit_count;
    logic [IW-1:0]   stuff_count;
    int              n_assert, n_fail, cyc, exp_stuff;
    bit              exp_q[$];
    can_bit_streamer #(.MAX_FRAME_LEN(MAXL), .CLK_PER_BIT(CLK), .SAMPLE_POS(SP)) dut (
        .clock        (clk),
        .reset        (reset),
        .frame_bits   (frame_bits),
        .num_bits     (num_bits),
        .stuff_len    (stuff_len),
        .repeat_cnt   (repeat_cnt),
        .gap_bits     (gap_bits),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rx_bit       (rx_bit),
        .sample_point (sample_point),
        .bit_count    (bit_count),
        .stuff_count  (stuff_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // clocks since reset release; its value mod CLK is the expected bit-time position
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;
    assign bit_count_unused_guard = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    // expected bus level per bit time for the whole transfer, gaps included
    task automatic build(input logic [63:0] fr, input int nb, input int sl, input int rp, input int gp);
        bit one[$];
        int run, n;
        bit b;
        exp_q.delete();
        exp_stuff = 0;
        n = (nb > MAXL) ? MAXL : nb;
        if (n == 0) return;
        run = 0;
        for (int p = 0; p < n; p++) begin
            b = fr[n-1-p];
            run = (one.size() > 0 && one[one.size()-1] == b) ? run + 1 : 1;
            one.push_back(b);
`ifdef CAN_STREAM_STUFF_EN
            if (run == 5 && p < sl) begin
                one.push_back(!b);
                run = 1;
                exp_stuff++;
            end
`endif
        end
        for (int r = 0; r <= rp; r++) begin
            foreach (one[i]) exp_q.push_back(one[i]);
            if (r < rp) for (int g = 0; g < gp; g++) exp_q.push_back(1'b1);
        end
    endtask
    task automatic run_txn(input logic [63:0] fr, input int nb, input int sl, input int rp, input int gp, input int kw);
        int k, done_m, gm, b, nc;
        build(fr, nb, sl, rp, gp);
        nc = (nb > MAXL) ? MAXL : nb;
        @(negedge clk);
        while ((cyc % CLK) != kw) @(negedge clk);
        frame_bits = fr;
        num_bits   = IW'(nb);
        stuff_len  = IW'(sl);
        repeat_cnt = 8'(rp);
        gap_bits   = 8'(gp);
        start      = 1'b1;
        k = kw;
        done_m = CLK - k + exp_q.size() * CLK;
        gm = (done_m > 3) ? $urandom_range(2, done_m - 1) : 0;
        for (int m = 1; m <= done_m + 1; m++) begin
            @(negedge clk);
            chk("sample_point", sample_point, ((k + m) % CLK) == SP);
            if (m < CLK - k) begin
                chk("arm_rx", rx_bit, 1);
                chk("arm_busy", busy, 1);
                chk("arm_done", done, 0);
            end else if (m < done_m) begin
                b = (m - (CLK - k)) / CLK;
                chk("rx_bit", rx_bit, exp_q[b]);
                chk("busy", busy, 1);
                chk("done_early", done, 0);
            end else if (m == done_m) begin
                chk("done_pulse", done, 1);
                chk("end_busy", busy, 0);
                chk("end_rx", rx_bit, 1);
                if (nc > 0) begin
                    chk("bit_count", bit_count, nc + exp_stuff);
                    chk("stuff_count", stuff_count, exp_stuff);
                end
            end else begin
                chk("done_single", done, 0);
                chk("idle_rx", rx_bit, 1);
            end
            start = (m == gm);
            if (m == gm) begin
                frame_bits = {$urandom, $urandom};
                num_bits   = IW'($urandom_range(0, 100));
                stuff_len  = IW'($urandom_range(0, 100));
                repeat_cnt = 8'($urandom);
                gap_bits   = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask
    initial begin
        int k;
        logic [63:0] a, c;
        n_assert = 0;
        n_fail = 0;
        reset = 1'b0;
        start = 1'b0;
        frame_bits = '0;
        num_bits = '0;
        stuff_len = '0;
        repeat_cnt = '0;
        gap_bits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx", rx_bit, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample", sample_point, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_stuff_count", stuff_count, 0);
        reset = 1'b1;
        run_txn(64'hB, 4, 0, 0, 0, 3);
        run_txn(64'h0, 8, 8, 0, 0, 0);
        run_txn(64'hA, 4, 4, 2, 3, 5);
        run_txn(64'h5, 0, 0, 3, 2, 2);
        run_txn(64'hF0F0_0F0F_F0F0_0F0F, 100, 100, 0, 0, 9);
        run_txn(64'h3, 4, 0, 1, 0, 8);
        // reset during the second bit of a four-bit frame
        build(64'hB, 4, 0, 0, 0);
        @(negedge clk);
        while ((cyc % CLK) != 4) @(negedge clk);
        frame_bits = 64'hB;
        num_bits = 4;
        repeat_cnt = 0;
        gap_bits = 0;
        start = 1'b1;
        k = 4;
        @(negedge clk);
        start = 1'b0;
        repeat (CLK - k + CLK + 2) @(negedge clk);
        chk("abort_pre_rx", rx_bit, exp_q[1]);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rx", rx_bit, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bit_count", bit_count, 0);
        reset = 1'b1;
        for (int i = 0; i < 5 * CLK; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        run_txn(64'hB, 4, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            int nb;
            a = {$urandom, $urandom};
            c = {$urandom, $urandom};
            nb = $urandom_range(0, 24);
            run_txn(i[0] ? (a & c) : (a | c), nb, $urandom_range(0, nb), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, CLK - 1));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
